slt_seq_n: RTL

Parametrised, multi-cycle set-less-than unit. It is the successor to the combinational 32-bit slt block and adds generic width, a signed/unsigned mode, and valid/ready handshakes on both sides. It computes rs - rt LSB-first, CHUNK bits per cycle, through a registered borrow chain, then produces rd = {0..0, lt} and the signed-overflow flag. It is intended as the compare datapath for a multi-cycle ALU / execute stage.

---
 rtl/slt_seq_n.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/slt_seq_n.sv
// slt_seq_n: multi-cycle set-less-than unit.
//
// Computes rs - rt LSB-first, CHUNK bits per cycle, through a registered
// borrow chain. It then returns rd = {0..0, lt} and the signed-overflow flag.
// Valid/ready handshakes are used on both the input and output sides.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   CHUNK  bits subtracted per cycle; must divide WIDTH
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_valid      rs/rt/is_unsigned valid
//   in_ready      unit idle and able to accept
//   rs, rt        operands
//   is_unsigned   1 = sltu, 0 = signed slt
//   out_valid     rd/overflow (and eq) valid
//   out_ready     consumer takes the result
//   rd            {(WIDTH-1) zeros, lt}
//   overflow      signed overflow of rs - rt; 0 in unsigned mode
//   eq            (only with SLT_SEQ_EQ_EN) 1 when rs == rt
//
// Optional feature macro: SLT_SEQ_EQ_EN adds the eq output and the zero-detect logic.

module slt_seq_n #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             is_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             overflow
`ifdef SLT_SEQ_EQ_EN
    ,
    output logic             eq
`endif
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = $clog2(NCHUNK) + 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
    localparam logic [CW-1:0] NCH  = CW'(NCHUNK);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rs_q, rt_q, diff_q;
    logic             borrow_q;
    logic [CW-1:0]    idx_q;
    logic             uns_q;

    int unsigned      base;
    logic [CHUNK:0]   sub;
    logic [WIDTH-1:0] diff_n;
    logic             ovf_n;
    logic             lt_n;

    // Chunk datapath: one CHUNK-wide subtract per cycle with borrow-in from the previous chunk.
    always_comb begin
        base   = 0;
        sub    = '0;
        diff_n = diff_q;
        ovf_n  = 1'b0;
        lt_n   = 1'b0;
        // Guard keeps the part-select in range once idx_q has moved past the last chunk.
        if (idx_q < NCH) begin
            base = 32'(idx_q) * CHUNK;
        end
        sub = {1'b0, rs_q[base +: CHUNK]} - {1'b0, rt_q[base +: CHUNK]} - (CHUNK+1)'(borrow_q);
        diff_n[base +: CHUNK] = sub[CHUNK-1:0];
        ovf_n = (rs_q[WIDTH-1] != rt_q[WIDTH-1]) && (diff_n[WIDTH-1] != rs_q[WIDTH-1]);
        lt_n  = uns_q ? sub[CHUNK] : (diff_n[WIDTH-1] ^ ovf_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rs_q      <= '0;
            rt_q      <= '0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            idx_q     <= '0;
            uns_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rd        <= '0;
            overflow  <= 1'b0;
`ifdef SLT_SEQ_EQ_EN
            eq        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        rs_q     <= rs;
                        rt_q     <= rt;
                        uns_q    <= is_unsigned;
                        borrow_q <= 1'b0;
                        idx_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    diff_q   <= diff_n;
                    borrow_q <= sub[CHUNK];
                    idx_q    <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        rd        <= {{(WIDTH-1){1'b0}}, lt_n};
                        overflow  <= uns_q ? 1'b0 : ovf_n;
`ifdef SLT_SEQ_EQ_EN
                        eq        <= (diff_n == '0);
`endif
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    // Results are held in rd/overflow after the handshake until the next op ends.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
